// File: rtl/gcd_arbiter_if.sv
// Purpose: bundle of requester, response, engine and status signals for gcd_arbiter.
// Latency: none (pure wiring).
// Backpressure: req_valid/req_ready per requester, rsp_valid/rsp_ready on the response side.
interface gcd_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Requester side: NREQ slots, operands packed slot i at [i*WIDTH +: WIDTH]
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_in1;
    logic [NREQ*WIDTH-1:0] req_in2;
    logic [NREQ-1:0]       req_ready;

    // Response side
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_err;

    // Shared engine
    logic [WIDTH-1:0]      eng_in1;
    logic [WIDTH-1:0]      eng_in2;
    logic                  eng_reset;
    logic [WIDTH-1:0]      eng_out;
    logic                  eng_done;

    // Status
    logic                  busy;

    // Arbiter view
    modport slave (
        input  req_valid, req_in1, req_in2, rsp_ready, eng_out, eng_done,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
               eng_in1, eng_in2, eng_reset, busy
    );

    // Environment view: requesters, response consumer and the engine itself
    modport master (
        output req_valid, req_in1, req_in2, rsp_ready, eng_out, eng_done,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
               eng_in1, eng_in2, eng_reset, busy
    );
endinterface

// File: rtl/gcd_arbiter.sv
// Purpose: round-robin scheduler sharing one gcd engine among NREQ requesters, with zero bypass and watchdog.
// Latency: grant combinational; engine job = 2 START cycles + RUN until done/timeout; zero bypass = 1 cycle.
// Backpressure: one grant per IDLE visit; RESP holds until rsp_ready, req_ready all-zero meanwhile.
module gcd_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic           clk,
    input  logic           reset,
    gcd_arbiter_if.slave   bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic             r_start_cnt;
    logic [15:0]      r_wd;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_err;
    // Engine operand registers double as the latched op_a/op_b of the current
    // job; the bypass path never writes them so the engine view stays intact.
    logic [WIDTH-1:0] r_eng_in1;
    logic [WIDTH-1:0] r_eng_in2;

    logic             w_any;
    logic [IDW-1:0]   w_gidx;
    logic [NREQ-1:0]  w_onehot;
    logic [WIDTH-1:0] w_in1;
    logic [WIDTH-1:0] w_in2;
    logic             w_bypass;

    // Round-robin search: first valid requester starting at ptr+1 with wrap
    always_comb begin
        w_any    = 1'b0;
        w_gidx   = '0;
        w_onehot = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_any && bus.req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_any    = 1'b1;
                w_gidx   = IDW'((int'(r_ptr) + k) % NREQ);
                w_onehot[(int'(r_ptr) + k) % NREQ] = 1'b1;
            end
        end
    end

    assign w_in1    = bus.req_in1[int'(w_gidx)*WIDTH +: WIDTH];
    assign w_in2    = bus.req_in2[int'(w_gidx)*WIDTH +: WIDTH];
    assign w_bypass = (w_in1 == '0) || (w_in2 == '0);

    assign bus.req_ready = (r_state == S_IDLE) ? w_onehot : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.eng_in1   = r_eng_in1;
    assign bus.eng_in2   = r_eng_in2;
    assign bus.busy      = (r_state != S_IDLE);
    // Engine is held in clear whenever our reset is asserted, so it cannot run
    // on stale operands while the arbiter itself is being reset.
    assign bus.eng_reset = (!reset) || (r_state == S_START);

    // Job sequencer: grant/latch, engine clear-load, run with watchdog, response hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= PTR_RST;
            r_start_cnt <= 1'b0;
            r_wd        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_err   <= 1'b0;
            r_eng_in1   <= '0;
            r_eng_in2   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ptr    <= w_gidx;
                        r_rsp_id <= w_gidx;
                        if (w_bypass) begin
                            // gcd(x,0)=x and gcd(0,0)=0, so OR gives the answer
                            r_rsp_data  <= w_in1 | w_in2;
                            r_rsp_err   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_eng_in1   <= w_in1;
                            r_eng_in2   <= w_in2;
                            r_start_cnt <= 1'b0;
                            r_state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    // Two clear/load cycles also flush any done level left by the previous job
                    if (r_start_cnt) begin
                        r_wd    <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_start_cnt <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.eng_done) begin
                        r_rsp_data  <= bus.eng_out;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_wd == WD_LAST) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wd <= r_wd + 16'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
